// File: rtl/banner_pkg.sv
// Shared constants for the scrolling 7-segment banner:
// message ROM, segment patterns and window index helper.
package banner_pkg;

    localparam int MSG_LEN = 10;

    localparam logic [3:0] MSG [MSG_LEN] = '{
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
        4'd5, 4'd6, 4'd7, 4'd8, 4'd9
    };

    // Active-low {dp,g,f,e,d,c,b,a}, dp always off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [3:0] msg_idx(
        input logic [3:0] base,
        input logic [1:0] off
    );
        logic [4:0] s;
        s = {1'b0, base} + {3'b000, off};
        if (s >= 5'(MSG_LEN)) s = s - 5'(MSG_LEN);
        return s[3:0];
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational 4-bit code to active-low 7-segment pattern;
// codes outside 0..9 blank the digit.
module hex_to_sseg
    import banner_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [7:0] sseg_o
);

    always_comb begin
        sseg_o = SEG_BLANK;
        case (hex_i)
            4'd0:    sseg_o = SEG_0;
            4'd1:    sseg_o = SEG_1;
            4'd2:    sseg_o = SEG_2;
            4'd3:    sseg_o = SEG_3;
            4'd4:    sseg_o = SEG_4;
            4'd5:    sseg_o = SEG_5;
            4'd6:    sseg_o = SEG_6;
            4'd7:    sseg_o = SEG_7;
            4'd8:    sseg_o = SEG_8;
            4'd9:    sseg_o = SEG_9;
            default: sseg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/rotating_banner.sv
// Scrolls a 10-char message through a 4-digit multiplexed
// common-anode display; scroll pauses with en, refresh never does.
module rotating_banner
    import banner_pkg::*;
#(
    parameter int SCROLL_DIV   = 50_000_000,
    parameter int REFRESH_BITS = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    output logic [3:0] an,
    output logic [7:0] sseg
);

    localparam int TW = $clog2(SCROLL_DIV);
    localparam logic [TW-1:0] TLAST = TW'(SCROLL_DIV - 1);
    localparam logic [3:0] PLAST = 4'(MSG_LEN - 1);

    logic [TW-1:0]           tcnt_q, tcnt_d;
    logic [3:0]              ptr_q, ptr_d;
    logic [REFRESH_BITS-1:0] rcnt_q;
    logic                    tick;
    logic [1:0]              sel;
    logic [3:0]              code;

    always_comb begin
        tick   = en && (tcnt_q == TLAST);
        tcnt_d = tcnt_q;
        ptr_d  = ptr_q;
        if (tick) begin
            tcnt_d = '0;
            if (dir) ptr_d = (ptr_q == 4'd0) ? PLAST : ptr_q - 4'd1;
            else     ptr_d = (ptr_q == PLAST) ? 4'd0 : ptr_q + 4'd1;
        end else if (en) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Reset wins over a tick landing in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q <= '0;
            ptr_q  <= '0;
            rcnt_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            ptr_q  <= ptr_d;
            rcnt_q <= rcnt_q + REFRESH_BITS'(1);
        end
    end

    assign sel = rcnt_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        an = 4'b1111;
        unique case (sel)
            2'd0: an = 4'b1110;
            2'd1: an = 4'b1101;
            2'd2: an = 4'b1011;
            2'd3: an = 4'b0111;
        endcase
    end

    // Rightmost digit (sel 0) is furthest from ptr
    assign code = MSG[msg_idx(ptr_q, 2'd3 - sel)];

    hex_to_sseg u_dec (
        .hex_i  (code),
        .sseg_o (sseg)
    );

endmodule

// File: tb/tb_rotating_banner.sv
// Directed bench for rotating_banner with SCROLL_DIV=4,
// REFRESH_BITS=4; expected ptr values are hand-derived per step.
module tb_rotating_banner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] an;
    logic [7:0] sseg;

    int vectors = 0;
    int miscompares = 0;
    int rc = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] seg_tab [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    rotating_banner #(
        .SCROLL_DIV   (4),
        .REFRESH_BITS (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .dir   (dir),
        .an    (an),
        .sseg  (sseg)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (reset) rc = 0;
            else rc = (rc + 1) % 16;
            #1;
        end
    endtask

    task automatic chk_raw(input string tag,
                           input logic [3:0] ea,
                           input logic [7:0] es);
        vectors++;
        assert (an === ea) else begin
            miscompares++;
            $error("FAIL %s an got=%b want=%b", tag, an, ea);
        end
        vectors++;
        assert (sseg === es) else begin
            miscompares++;
            $error("FAIL %s sseg got=%h want=%h", tag, sseg, es);
        end
    endtask

    task automatic chk(input string tag, input int p);
        int s;
        int d;
        s = rc / 4;
        d = (p + 3 - s) % 10;
        chk_raw(tag, an_tab[s], seg_tab[d]);
    endtask

    initial begin
        // 1: reset and refresh rotation, scroll disabled
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        chk_raw("rst_d0", 4'b1110, 8'hB0);
        step(4);
        chk_raw("rst_d1", 4'b1101, 8'hA4);
        step(4);
        chk_raw("rst_d2", 4'b1011, 8'hF9);
        step(4);
        chk_raw("rst_d3", 4'b0111, 8'hC0);
        step(4);
        chk_raw("rst_wrap", 4'b1110, 8'hB0);

        // 2: scroll right, ptr 0 -> 9 -> ... -> 0
        en = 1'b1;
        dir = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(3);
            chk("right_hold", (11 - i) % 10);
            step(1);
            chk("right_tick", (10 - i) % 10);
        end

        // 3: scroll left with 9 -> 0 wrap
        dir = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(3);
            chk("left_hold", i - 1);
            step(1);
            chk("left_tick", i % 10);
        end

        // 4: pause mid-interval, refresh keeps running
        step(2);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(10);
            chk("pause", 0);
        end
        en = 1'b1;
        step(1);
        chk("resume_hold", 0);
        step(1);
        chk("resume_tick", 1);

        // 5: direction change mid-interval
        dir = 1'b1;
        step(4);
        chk("dir_dec", 0);
        step(2);
        dir = 1'b0;
        step(1);
        chk("dir_hold", 0);
        step(1);
        chk("dir_inc", 1);

        // 6: reset on the tick cycle with ptr=5
        step(16);
        chk("pre_rst", 5);
        step(3);
        chk("tick_pend", 5);
        reset = 1'b1;
        step(1);
        chk_raw("rst_mid", 4'b1110, 8'hB0);
        reset = 1'b0;
        step(3);
        chk("post_rst_hold", 0);
        step(1);
        chk("post_rst_tick", 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rotating_banner.md
# rotating_banner

Scrolling-message driver for a 4-digit, common-anode, multiplexed 7-segment display. A fixed 10-character message ("0123456789") is shown through a 4-character window. The window rotates one position per scroll tick, left or right under `dir`, and pauses while `en` is low. The block sits between board-level switches and the display pins, driving active-low anodes and segments directly.

## Interface
- `SCROLL_DIV`, 50_000_000: clock cycles per scroll step (≥2).
- `REFRESH_BITS`, 18: refresh counter width. Its top 2 bits select the active digit (≥3).
- `clk` in 1: system clock, 100 MHz on board.
- `reset` in 1: one clock; reset is synchronous and active-high.
- `en` in 1: 1 = scroll; 0 = freeze window. Display refresh continues regardless.
- `dir` in 1: 1 = text moves right; 0 = text moves left. Sampled at each scroll tick.
- `an` out 4: digit enables, active low. `an[3]` is the leftmost digit, `an[0]` the rightmost.
- `sseg` out 8: segments, active low. `sseg[7]` = dp, `sseg[6:0]` = {g,f,e,d,c,b,a}.

## Operation
- Message `MSG[0..9]` = digits 0..9. Pointer `ptr` ∈ 0..9.
- Window mapping:
  - `an[3]` shows MSG[ptr]
  - `an[2]` shows MSG[(ptr+1) mod 10]
  - `an[1]` shows MSG[(ptr+2) mod 10]
  - `an[0]` shows MSG[(ptr+3) mod 10]
- Scroll tick:
  - `tcnt` counts 0..SCROLL_DIV-1, but only while `en`=1. It holds its value while `en`=0, so resuming continues the partial interval.
  - At `tcnt`=SCROLL_DIV-1 with `en`=1: `tcnt` resets to 0 and `ptr` updates.
  - `dir`=1: ptr ← (ptr+9) mod 10, i.e. decrement with wrap 0→9.
  - `dir`=0: ptr ← (ptr+1) mod 10, with wrap 9→0.
- Refresh:
  - `rcnt` free-runs, wrapping at 2^REFRESH_BITS.
  - `sel` = `rcnt[REFRESH_BITS-1 -: 2]`.
  - `sel`=0 drives `an`=1110 (digit 0); `sel`=1 → 1101; `sel`=2 → 1011; `sel`=3 → 0111.
  - Exactly one anode is low at all times.
- Decoder, hex → `sseg`, with dp always off:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99
  - 5=92, 6=82, 7=F8, 8=80, 9=90
  - Any other code = FF (blank).
- Reset values: `ptr`=0, `tcnt`=0, `rcnt`=0. Hence `an`=1110 and `sseg`=B0 (the digit "3") in the cycle after reset.
- Reset asserted mid-scroll overrides any pending tick in the same cycle.

## Timing
- `ptr`, `tcnt` and `rcnt` are registered. `an`/`sseg` are combinational from these registers, so there are no glitches beyond the register outputs.
- Scroll step period is exactly SCROLL_DIV cycles of `en`=1.
- A change to `dir` takes effect at the next tick. There is no extra latency.
- The new `ptr` is visible on `sseg` in the cycle after the tick edge.
- Each digit is held for 2^(REFRESH_BITS-2) cycles. A full frame is 2^REFRESH_BITS cycles.
- `en` falling in the same cycle as a would-be tick suppresses that tick.

## Structure
- Package `banner_pkg` holds:
  - `MSG_LEN`=10
  - the message ROM constant (10 × 4-bit)
  - the segment code constants
- Sub-module `hex_to_sseg`: 4-bit code in → 8-bit active-low pattern out, purely combinational.
- Top level contains the tick counter, pointer, refresh counter, anode decode and digit mux.

## Test plan
All scenarios use SCROLL_DIV=4 and REFRESH_BITS=4, so each digit is held for 4 cycles.

1. **Reset.** Assert `reset` for 2 cycles, then release. Required: `an`=1110, `sseg`=B0. Over the next 16 cycles, `an` sequences 1110 → 1101 → 1011 → 0111, showing "3", "2", "1", "0" respectively (`sseg` = B0, A4, F9, C0).
2. **Scroll right.** `en`=1, `dir`=1 from reset. After 4 cycles `ptr`=9: the window reads "9012", so `an`=0111 shows 90. After 40 cycles `ptr` returns to 0.
3. **Scroll left with wrap.** `en`=1, `dir`=0. `ptr` steps 0 → 1 → … → 9 → 0 at 4-cycle intervals. At `ptr`=8 the window reads "8901": digit 0 shows F9.
4. **Pause.** After 2 tick-counter cycles, set `en`=0 for 50 cycles. Required: `ptr` and `tcnt` are unchanged, while `an` keeps rotating. On setting `en`=1, `ptr` changes after 2 more cycles.
5. **Direction change.** `dir` toggles from 1 to 0 mid-interval. The next tick increments `ptr`; the previous tick had decremented it.
6. **Reset mid-run.** Assert `reset` at the tick cycle with `ptr`=5. Required: `ptr`=0, `an`=1110, `sseg`=B0 on the next cycle.
